// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: multiply/divide op encodings and FSM states.
package mips_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    ITER  = 2'd2,
    FIX   = 2'd3
  } md_state_e;

  function automatic logic is_iter_op(input logic [2:0] o);
    return (o <= MD_DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational iteration of shift-add multiply (mode=0) or restoring divide (mode=1).
module mips_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sreg,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] sreg_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + (sreg[0] ? {1'b0, operand} : '0);
    shifted = {acc, sreg[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    if (mode) begin
      // borrow out of the trial subtraction means the remainder is restored
      acc_nxt  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      sreg_nxt = {sreg[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      {acc_nxt, sreg_nxt} = {sum, sreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; also services MTHI/MTLO.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last;

  logic             ld_req, ld_setup, iter_en, wr_res, wr_hi, wr_lo;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc, sreg, opnd;
  logic [WIDTH-1:0] acc_nxt, sreg_nxt;
  logic             neg_q, neg_r, divz, ovf;
  logic             sgn_op;
  logic [2*WIDTH-1:0] res;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (sgn && sv < 0) ? -v : v;
  endfunction

  // Sign fix-up and divide special cases; returns {hi, lo}
  function automatic logic [2*WIDTH-1:0] fixup(
    input logic             is_div,
    input logic [WIDTH-1:0] acc_f,
    input logic [WIDTH-1:0] sreg_f,
    input logic [WIDTH-1:0] a_raw,
    input logic             nq,
    input logic             nr,
    input logic             dz,
    input logic             of
  );
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rh, rl;
    prod = {acc_f, sreg_f};
    if (!is_div) begin
      return nq ? -prod : prod;
    end else if (dz) begin
      return {a_raw, {WIDTH{1'b1}}};
    end else if (of) begin
      return {{WIDTH{1'b0}}, a_raw};
    end else begin
      rh = nr ? -acc_f : acc_f;
      rl = nq ? -sreg_f : sreg_f;
      return {rh, rl};
    end
  endfunction

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode     (op_q[1]),
    .acc      (acc),
    .sreg     (sreg),
    .operand  (opnd),
    .acc_nxt  (acc_nxt),
    .sreg_nxt (sreg_nxt)
  );

  assign sgn_op = ~op_q[0];
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign res    = fixup(op_q[1], acc_nxt, sreg_nxt, a_q, neg_q, neg_r, divz, ovf);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && is_iter_op(op)) state_nxt = SETUP;
      SETUP:   state_nxt = ITER;
      ITER:    if (last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_req   = (state == IDLE) && start && is_iter_op(op);
    wr_hi    = (state == IDLE) && start && (op == MD_MTHI);
    wr_lo    = (state == IDLE) && start && (op == MD_MTLO);
    ld_setup = (state == SETUP);
    iter_en  = (state == ITER);
    wr_res   = (state == ITER) && last;
  end

  // Control: counter and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      if (ld_setup)     cnt <= '0;
      else if (iter_en) cnt <= cnt + CNT_W'(1);
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == FIX);
    end
  end

  // Datapath: request capture, setup of magnitudes/signs, iteration
  always_ff @(posedge clk) begin
    if (ld_req) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
    if (ld_setup) begin
      acc   <= '0;
      neg_q <= sgn_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
      neg_r <= sgn_op & a_q[WIDTH-1];
      divz  <= op_q[1] && (b_q == '0);
      ovf   <= (op_q == MD_DIV) && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
      if (op_q[1]) begin
        sreg <= mag(a_q, sgn_op);
        opnd <= mag(b_q, sgn_op);
      end else begin
        sreg <= mag(b_q, sgn_op);
        opnd <= mag(a_q, sgn_op);
      end
    end else if (iter_en) begin
      acc  <= acc_nxt;
      sreg <= sreg_nxt;
    end
  end

  // Architectural HI/LO: only the final result or MTHI/MTLO may change them
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (wr_res) begin
      {hi, lo} <= res;
    end else begin
      if (wr_hi) hi <= a;
      if (wr_lo) lo <= a;
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: vector table, model-driven random ops and handshake corner sequences.
module tb_mips_muldiv;
  import mips_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi, lo;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  mips_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sp;
    logic [2*W-1:0]        up;
    exp_t r;
    r.hi = x;
    r.lo = '1;
    case (o)
      MD_MULT: begin
        sp = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
        {r.hi, r.lo} = sp;
      end
      MD_MULTU: begin
        up = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        {r.hi, r.lo} = up;
      end
      MD_DIV: begin
        if (y == '0) begin
          r.hi = x;
          r.lo = '1;
        end else if (x == {1'b1, {(W-1){1'b0}}} && y == '1) begin
          r.hi = '0;
          r.lo = x;
        end else begin
          r.lo = $signed(x) / $signed(y);
          r.hi = $signed(x) % $signed(y);
        end
      end
      MD_DIVU: begin
        if (y != '0) begin
          r.lo = x / y;
          r.hi = x % y;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input exp_t e);
    int           edges;
    logic [W-1:0] h0, l0;
    logic         held;
    exp_t         got_e;
    h0 = hi;
    l0 = lo;
    held = 1'b1;
    sb.push_back(e);
    issue(o, x, y);
    edges = 1;
    chk({name, " busy_after_start"}, 64'(busy), 64'd1);
    while (!done && edges < 3 * W) begin
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(posedge clk);
      #1 edges++;
    end
    chk({name, " hilo_held"}, 64'(held), 64'd1);
    chk({name, " latency"}, 64'(edges), 64'(W + 2));
    chk({name, " busy_with_done"}, 64'(busy), 64'd1);
    if (sb.size() > 0) begin
      got_e = sb.pop_front();
      chk({name, " hilo"}, {hi, lo}, {got_e.hi, got_e.lo});
    end
    @(posedge clk);
    #1;
    chk({name, " idle_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    exp_t         e;
    logic [2:0]   o;
    logic [W-1:0] x, y, h0, l0;
    int           edges;
    logic         seen;

    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {62'd0, busy, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    tbl[0] = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    tbl[4] = '{MD_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    tbl[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[6] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[7] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[8] = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    tbl[9] = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};

    for (int i = 0; i < 10; i++) begin
      e.hi = tbl[i].hi;
      e.lo = tbl[i].lo;
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, e);
    end

    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      run_op($sformatf("rnd%0d", i), o, x, y, model(o, x, y));
    end

    // MTHI / MTLO while idle
    issue(MD_MTHI, 32'h00001234, 32'h0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_ctrl", {62'd0, busy, done}, 64'd0);
    issue(MD_MTLO, 32'h00005678, 32'h0);
    chk("mtlo_lo", {hi, lo}, {32'h1234, 32'h5678});
    chk("mtlo_ctrl", {62'd0, busy, done}, 64'd0);

    // Undefined op code: accepted but nothing changes
    issue(3'd7, 32'hFFFF0000, 32'h3);
    chk("nop_hilo", {hi, lo}, {32'h1234, 32'h5678});
    @(posedge clk);
    #1;
    chk("nop_ctrl", {62'd0, busy, done}, 64'd0);

    // MTLO held on start throughout a MULT, including the done cycle: ignored
    e = model(MD_MULT, 32'h00012345, 32'hFFFFFF00);
    sb.push_back(e);
    issue(MD_MULT, 32'h00012345, 32'hFFFFFF00);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op    = MD_MTLO;
    a     = 32'hDEADBEEF;
    edges = 0;
    while (!done && edges < 3 * W) begin
      @(posedge clk);
      #1 edges++;
    end
    chk("ovl_done_seen", 64'(done), 64'd1);
    e = sb.pop_front();
    chk("ovl_hilo", {hi, lo}, {e.hi, e.lo});
    @(posedge clk);
    #1 start = 1'b0;
    chk("ovl_hilo_after", {hi, lo}, {e.hi, e.lo});
    chk("ovl_idle", {62'd0, busy, done}, 64'd0);

    // Reset 10 cycles into a DIV aborts it and clears HI/LO
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_ctrl", {62'd0, busy, done}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done || busy) seen = 1'b1;
    end
    chk("rst_mid_no_done", 64'(seen), 64'd0);
    e.hi = 32'd0;
    e.lo = 32'd3;
    run_op("restart_divu", MD_DIVU, 32'd9, 32'd3, e);

    h0 = hi;
    l0 = lo;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("final_hilo", {h0, l0}, {32'd0, 32'd3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
